// File: rtl/softmax_norm_if.sv
// Stream bundle for softmax_norm: element input, probability output and
// the credit return path from the downstream consumer.
interface softmax_norm_if #(
  parameter int CREDITS = 2
);
  localparam int CW = $clog2(CREDITS + 1);

  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_last;
  logic          credit_in;
  logic [CW-1:0] credit_count;

  modport master (
    output in_valid, in_data, credit_in,
    input  in_ready, out_valid, out_data, out_last, credit_count
  );

  modport slave (
    input  in_valid, in_data, credit_in,
    output in_ready, out_valid, out_data, out_last, credit_count
  );
endinterface

// File: rtl/softmax_norm.sv
// Row-wise softmax normalizer: buffers a row of Q2.6 exponents, sums them,
// then emits each element / sum as Q1.7 under downstream credit control.
module softmax_norm #(
  parameter int ROW_LEN = 8,
  parameter int CREDITS = 2
) (
  input  logic         clk,
  input  logic         rst,
  softmax_norm_if.slave s
);
  localparam int IW = $clog2(ROW_LEN);
  localparam int SW = 8 + IW;
  localparam int CW = $clog2(CREDITS + 1);

  typedef enum logic [1:0] {FILL, DIV, SEND} state_t;

  state_t                   state, state_nxt;
  logic [ROW_LEN-1:0][7:0]  row_buf;
  logic [SW-1:0]            sum;
  logic [IW-1:0]            idx;
  logic [2:0]               dcnt;
  logic [SW-1:0]            rem;
  logic [7:0]               quo;
  logic [CW-1:0]            credits;
  logic [7:0]               out_data_q;
  logic                     out_last_q;

  logic          accept, fire, last_idx;
  logic [SW:0]   trial, diff;
  logic          ge;
  logic [7:0]    qout;

  assign accept   = s.in_valid && (state == FILL);
  assign last_idx = (idx == IW'(ROW_LEN - 1));
  assign fire     = (state == SEND) && (credits != '0);

  // Numerator is elem<<7: its top seven bits seed the remainder and the
  // element LSB is the first bit shifted in, so step 0 starts from the
  // raw element and every later step shifts in a zero.
  assign trial = (dcnt == 3'd0) ? {{(SW-7){1'b0}}, row_buf[idx]} : {rem, 1'b0};
  assign diff  = trial - {1'b0, sum};
  assign ge    = (trial >= {1'b0, sum});
  assign qout  = (sum == '0) ? 8'h00 : quo;

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && last_idx) state_nxt = DIV;
      DIV:     if (dcnt == 3'd7) state_nxt = SEND;
      SEND:    if (fire) state_nxt = last_idx ? FILL : DIV;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_buf    <= '0;
      sum        <= '0;
      idx        <= '0;
      dcnt       <= '0;
      rem        <= '0;
      quo        <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          dcnt <= '0;
          if (accept) begin
            row_buf[idx] <= s.in_data;
            sum          <= sum + SW'(s.in_data);
            idx          <= last_idx ? '0 : idx + 1'b1;
          end
        end
        DIV: begin
          rem  <= ge ? diff[SW-1:0] : trial[SW-1:0];
          quo  <= {quo[6:0], ge};
          dcnt <= dcnt + 3'd1;
        end
        SEND: begin
          if (fire) begin
            out_data_q <= qout;
            out_last_q <= last_idx;
            if (last_idx) begin
              sum <= '0;
              idx <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Simultaneous return and send cancel; returns beyond the cap are dropped.
  always_ff @(posedge clk) begin
    if (rst) credits <= CW'(CREDITS);
    else begin
      case ({s.credit_in, fire})
        2'b10:   if (credits < CW'(CREDITS)) credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: ;
      endcase
    end
  end

  assign s.in_ready     = (state == FILL);
  assign s.out_valid    = fire;
  assign s.out_data     = fire ? qout : out_data_q;
  assign s.out_last     = fire ? last_idx : out_last_q;
  assign s.credit_count = credits;
endmodule

// File: tb/tb_softmax_norm.sv
// Directed bench for softmax_norm: table of rows with hand-computed
// probabilities, plus credit-stall, credit corner and mid-row reset sequences.
module tb_softmax_norm;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  softmax_norm_if #(.CREDITS(2)) bus ();
  softmax_norm #(.ROW_LEN(8), .CREDITS(2)) dut (.clk(clk), .rst(rst), .s(bus));

  typedef struct packed {
    logic [7:0][7:0] din;
    logic [7:0][7:0] dout;
  } vec_t;

  vec_t vecs [6];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_row(input logic [7:0][7:0] d);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("in_ready_fill%0d", i), int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = d[i];
    end
  endtask

  // Auto credit return: each output's credit comes back in the same cycle.
  task automatic collect_row(input logic [7:0][7:0] exp, input string tag);
    int cyc = 0, got = 0, last_cyc = 0;
    while (got < 8 && cyc < 150) begin
      @(negedge clk);
      cyc++;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'hAA;
      bus.credit_in = bus.out_valid;
      if (bus.out_valid) begin
        chk($sformatf("%s_data%0d", tag, got), int'(bus.out_data), int'(exp[got]));
        chk($sformatf("%s_last%0d", tag, got), int'(bus.out_last), int'(got == 7));
        chk($sformatf("%s_gap%0d", tag, got), cyc - last_cyc, 9);
        last_cyc = cyc;
        got++;
      end
    end
    chk($sformatf("%s_count", tag), got, 8);
    @(negedge clk);
    bus.credit_in = 1'b0;
    chk($sformatf("%s_turn_ready", tag), int'(bus.in_ready), 1);
    chk($sformatf("%s_credits", tag), int'(bus.credit_count), 2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, tot, c;
    logic done;
    vecs[0].din  = {8{8'h40}};
    vecs[0].dout = {8{8'h10}};
    vecs[1].din  = {56'h0, 8'h40};
    vecs[1].dout = {56'h0, 8'h80};
    vecs[2].din  = {48'h0, 8'h01, 8'hFF};
    vecs[2].dout = {56'h0, 8'h7F};
    vecs[3].din  = {8{8'h00}};
    vecs[3].dout = {8{8'h00}};
    vecs[4].din  = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    vecs[4].dout = {8'd28, 8'd24, 8'd21, 8'd17, 8'd14, 8'd10, 8'd7, 8'd3};
    vecs[5].din  = {8{8'hFF}};
    vecs[5].dout = {8{8'h10}};

    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.credit_in = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_credits", int'(bus.credit_count), 2);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      send_row(vecs[v].din);
      collect_row(vecs[v].dout, $sformatf("row%0d", v));
    end

    // Credit stall: no returns, so only two outputs leave.
    send_row(vecs[0].din);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        n++;
        chk("stall_data", int'(bus.out_data), 8'h10);
      end
    end
    chk("stall_outputs", n, 2);
    chk("stall_credits", int'(bus.credit_count), 0);
    @(negedge clk);
    chk("stall_hold", int'(bus.out_valid), 0);
    bus.credit_in = 1'b1;
    @(negedge clk);
    bus.credit_in = 1'b0;
    chk("credit_release_valid", int'(bus.out_valid), 1);
    chk("credit_release_data", int'(bus.out_data), 8'h10);
    chk("credit_release_last", int'(bus.out_last), 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    chk("single_credit_extra", n, 0);
    chk("single_credit_count", int'(bus.credit_count), 0);

    // Return coincident with a send at count 1.
    @(negedge clk);
    chk("coinc_pre_valid", int'(bus.out_valid), 0);
    bus.credit_in = 1'b1;
    @(negedge clk);
    chk("coinc_fire", int'(bus.out_valid), 1);
    @(negedge clk);
    bus.credit_in = 1'b0;
    chk("coinc_count", int'(bus.credit_count), 1);

    tot = 4; c = 0; done = 1'b0;
    bus.credit_in = 1'b1;
    while (!done && c < 100) begin
      @(negedge clk);
      c++;
      if (bus.out_valid) begin
        tot++;
        chk($sformatf("drain_data%0d", tot), int'(bus.out_data), 8'h10);
        chk($sformatf("drain_last%0d", tot), int'(bus.out_last), int'(tot == 8));
        if (bus.out_last) done = 1'b1;
      end
    end
    chk("drain_total", tot, 8);
    @(negedge clk);
    chk("drain_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    chk("credit_saturate", int'(bus.credit_count), 2);
    bus.credit_in = 1'b0;

    // Mid-row reset discards three buffered elements.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", int'(bus.in_ready), 1);
    chk("midrst_credits", int'(bus.credit_count), 2);
    chk("midrst_out_data", int'(bus.out_data), 0);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    chk("midrst_no_output", n, 0);
    send_row(vecs[1].din);
    collect_row(vecs[1].dout, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/softmax_norm.md
# softmax_norm

Row-wise softmax normalizer for the attention engine. Sits directly downstream of the exponent stage: it buffers one score row of exponent results, accumulates their sum, and emits each element divided by the row sum as a probability. The downstream consumer throttles it with credit-based flow control.

## Interface

Parameters:
- ROW_LEN, 8: elements per score row. Must be a power of two and at least 2.
- CREDITS, 2: initial and maximum downstream credit count. Must be at least 1.

Ports:
- clk  in  1  clock; all logic updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream element valid.
- in_ready  out  1  block can accept an element.
- in_data  in  8  exponent result, unsigned Q2.6 (0 to 3.984).
- out_valid  out  1  one-cycle pulse; out_data is valid.
- out_data  out  8  probability, unsigned Q1.7 (0x80 = 1.0).
- out_last  out  1  high with the final element of a row.
- credit_in  in  1  one-cycle pulse; downstream returns one credit.
- credit_count  out  $clog2(CREDITS+1)  credits currently held.

## Operation

- Storage:
  - Row buffer of ROW_LEN x 8 bits.
  - Sum register, 8+log2(ROW_LEN) bits, unsigned. It never overflows.
  - Element index register, log2(ROW_LEN) bits.
- States:
  - FILL: in_ready=1. Each accept (in_valid & in_ready) writes buf[idx], adds in_data into sum, and increments idx. The accept at idx=ROW_LEN-1 resets idx to 0 and moves to DIV.
  - DIV: 8-cycle restoring division. Numerator = buf[idx] << 7 (15 bits); denominator = sum. Produces an 8-bit quotient, floor(buf[idx]*128/sum). After 8 cycles, moves to SEND.
  - SEND: if credit_count>0, assert out_valid for one cycle with out_data = quotient and out_last = (idx==ROW_LEN-1), decrement credits, then:
    - if idx==ROW_LEN-1, clear sum and idx and go to FILL;
    - otherwise increment idx and go to DIV.
  - SEND with credit_count=0: hold in SEND with out_valid=0 until a credit exists.
- Arithmetic:
  - Each element is at most the sum, so the quotient is at most 0x80. No clamping is needed.
  - sum==0: every quotient is forced to 0x00. The row still emits ROW_LEN outputs with out_last on the final one.
- Credits:
  - credit_in increments the count; a send decrements it.
  - A credit_in and a send in the same cycle leave the count unchanged.
  - credit_in at count==CREDITS is ignored; the count saturates.
- in_ready is 0 in DIV and SEND. in_data is ignored whenever no accept occurs.

## Timing

- Reset values:
  - state=FILL, idx=0, sum=0;
  - in_ready=1, out_valid=0, out_data=0x00, out_last=0;
  - credit_count=CREDITS.
- rst mid-row or mid-division discards all buffered data and the partial sum. in_ready is 1 in the first cycle after rst deasserts.
- Latency: if the final element of a row is accepted in cycle T, DIV occupies T+1..T+8 and the first out_valid is at T+9, given a credit is available.
- Per-element throughput: 9 cycles (8 DIV + 1 SEND) while credits are available. Each credit-stall cycle adds one cycle.
- Row turnaround: after the last SEND, the next cycle is FILL with in_ready=1.
- out_data and out_last hold their last values between pulses. Consumers sample only when out_valid=1.
- A credit_in arriving in the same cycle as a stalled SEND (count 0) is not visible until the next cycle, so out_valid fires one cycle later.

## Test plan

- **Uniform row:** 8 x 0x40 (sum 512), credits plentiful -> 8 outputs of 0x10, spaced 9 cycles apart. The first output comes 9 cycles after the last accept, and out_last is high only on the 8th.
- **One-hot and skewed rows:**
  - [0x40, 0, ..., 0] -> 0x80 then seven 0x00.
  - [0xFF, 0x01, 0, ...] (sum 256) -> 0x7F, 0x00, then zeros.
- **All-zero row:** 8 x 0x00 -> 8 outputs of 0x00 with out_last on the 8th, then returns to FILL with in_ready=1.
- **Credit stall:** CREDITS=2, no credit_in -> exactly 2 outputs, then out_valid stays 0 and credit_count=0. A single credit_in pulse -> exactly one further output, on the cycle after the credit becomes visible.
- **Credit corner cases:**
  - credit_in coincident with a send at count 1 -> count stays 1.
  - credit_in at count==CREDITS -> count unchanged.
- **Mid-row reset:** 3 elements accepted, then rst for 1 cycle -> in_ready=1, credit_count=CREDITS, and no output appears. The next 8 accepts form a fresh row whose outputs depend only on those 8 values.
